// File: rtl/ram_loader.sv
// ram_loader: shares the program RAM/MAR bus between the CPU and a byte-stream loader.
// Halts the CPU at an instruction boundary, writes consecutive addresses, optionally reads back.
module ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int WORDS  = 16,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_req,
    input  logic              cpu_halt_ack,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cpu_MI,
    input  logic              cpu_RI,
    input  logic              cpu_RO,
    input  logic [DATA_W-1:0] cpu_bus_out,
    input  logic              cpu_bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              MI,
    output logic              RI,
    output logic              RO,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [ADDR_W:0]   load_count
);
    typedef enum logic [2:0] {S_RUN, S_HALT, S_ACCEPT, S_ADDR, S_WRITE, S_VERIFY, S_FINISH} state_t;
    state_t st, nxt, step;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data, bus_r;
    logic mi_r, ri_r, ro_r, oe_r, busy_r, ready_r, done_r;
    logic run;
    always_comb begin
        step = (addr == ADDR_W'(WORDS - 1) || !prog_req) ? S_FINISH : S_ACCEPT;
        nxt = st;
        case (st)
            S_RUN:    nxt = prog_req ? S_HALT : S_RUN;
            S_HALT:   nxt = !prog_req ? S_RUN : cpu_halt_ack ? S_ACCEPT : S_HALT;
            S_ACCEPT: nxt = in_valid ? S_ADDR : !prog_req ? S_FINISH : S_ACCEPT;
            S_ADDR:   nxt = S_WRITE;
            S_WRITE:  nxt = (VERIFY != 0) ? S_VERIFY : step;
            S_VERIFY: nxt = step;
            S_FINISH: nxt = S_RUN;
            default:  nxt = S_RUN;
        endcase
    end
    // Loader strobes are registered from the next state so they are clean for the whole cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= S_RUN;
            addr       <= '0;
            data       <= '0;
            load_count <= '0;
            verify_err <= 1'b0;
            bus_r      <= '0;
            mi_r       <= 1'b0;
            ri_r       <= 1'b0;
            ro_r       <= 1'b0;
            oe_r       <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            st <= nxt;
            if (st == S_HALT && nxt == S_ACCEPT) begin
                addr       <= '0;
                load_count <= '0;
                verify_err <= 1'b0;
            end
            if (st == S_ACCEPT && in_valid) data <= in_data;
            if (st == S_WRITE) load_count <= load_count + 1'b1;
            if (st == S_VERIFY && bus_in != data) verify_err <= 1'b1;
            if ((st == S_WRITE || st == S_VERIFY) && nxt == S_ACCEPT) addr <= addr + 1'b1;
            bus_r   <= nxt == S_ADDR ? {{(DATA_W-ADDR_W){1'b0}}, addr} : nxt == S_WRITE ? data : '0;
            mi_r    <= nxt == S_ADDR;
            ri_r    <= nxt == S_WRITE;
            ro_r    <= nxt == S_VERIFY;
            oe_r    <= nxt == S_ADDR || nxt == S_WRITE;
            busy_r  <= nxt != S_RUN;
            ready_r <= nxt == S_ACCEPT;
            done_r  <= nxt == S_FINISH;
        end
    end
    assign run      = st == S_RUN;
    assign MI       = run ? cpu_MI : mi_r;
    assign RI       = run ? cpu_RI : ri_r;
    assign RO       = run ? cpu_RO : ro_r;
    assign bus_oe   = run ? cpu_bus_oe : oe_r;
    assign bus_out  = run ? cpu_bus_out : bus_r;
    assign busy     = busy_r;
    assign cpu_halt = busy_r;
    assign in_ready = ready_r;
    assign done     = done_r;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: drives load sessions into ram_loader with a RAM/MAR model and a write scoreboard.
module tb_ram_loader;
    logic clk = 0, rst = 0, prog_req = 0, cpu_halt_ack = 0, in_valid = 0, fault_en = 0;
    logic cpu_MI = 0, cpu_RI = 0, cpu_RO = 0, cpu_bus_oe = 0;
    logic [7:0] in_data = 0, cpu_bus_out = 0;
    logic [7:0] bus, bus_in, bus_out;
    logic in_ready, MI, RI, RO, bus_oe, cpu_halt, busy, done, verify_err;
    logic [4:0] load_count;
    logic [7:0] ram [16];
    logic [7:0] ref_ram [16];
    logic [3:0] mar;
    logic [11:0] sb [$];
    logic [11:0] e;
    int checks = 0, failures = 0, done_cnt = 0, n, d0;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk(clk), .rst(rst), .prog_req(prog_req), .cpu_halt_ack(cpu_halt_ack),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_MI(cpu_MI), .cpu_RI(cpu_RI), .cpu_RO(cpu_RO),
        .cpu_bus_out(cpu_bus_out), .cpu_bus_oe(cpu_bus_oe), .bus_in(bus_in),
        .MI(MI), .RI(RI), .RO(RO), .bus_out(bus_out), .bus_oe(bus_oe),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .verify_err(verify_err),
        .load_count(load_count)
    );

    assign bus    = bus_oe ? bus_out : RO ? ram[mar] : 8'h00;
    assign bus_in = (fault_en && RO && mar == 4'd5) ? 8'h00 : bus;

    always @(posedge clk) begin
        if (!rst) begin
            mar <= 4'd0;
            for (int i = 0; i < 16; i++) ram[i] <= 8'(8'hA0 + i);
        end else begin
            if (MI) mar <= bus[3:0];
            if (RI) ram[mar] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (RI && busy) begin
            if (sb.size() == 0) chk("sb_empty", 0, 1);
            else begin
                e = sb.pop_front();
                chk("wr_addr", {28'd0, mar}, {28'd0, e[11:8]});
                chk("wr_data", {24'd0, bus_out}, {24'd0, e[7:0]});
            end
        end
        if ((bus_oe && RO) || $countones({MI, RI, RO}) > 1) chk("strobe_excl", 1, 0);
    end

    task automatic wait_ready(output int k);
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] a, output int k);
        in_data = d;
        in_valid = 1;
        wait_ready(k);
        sb.push_back({a, d});
        ref_ram[a] = d;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic start_session();
        int k;
        prog_req = 1;
        repeat (3) @(negedge clk);
        chk("halt_before_ack", {31'd0, cpu_halt}, 1);
        cpu_halt_ack = 1;
        wait_ready(k);
        cpu_halt_ack = 0;
    endtask

    task automatic end_session();
        int k;
        prog_req = 0;
        k = 0;
        while (!done && k < 50) begin @(negedge clk); k++; end
        chk("done_seen", {31'd0, done}, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_ram[i] = 8'(8'hA0 + i);
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_halt", {31'd0, cpu_halt}, 0);
        chk("rst_ready", {31'd0, in_ready}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_count", {27'd0, load_count}, 0);
        chk("rst_verr", {31'd0, verify_err}, 0);
        rst = 1;
        @(negedge clk);
        // idle pass-through
        cpu_MI = 1; cpu_bus_oe = 1; cpu_bus_out = 8'h2F;
        #1;
        chk("pt_MI", {31'd0, MI}, 1);
        chk("pt_oe", {31'd0, bus_oe}, 1);
        chk("pt_bus", {24'd0, bus_out}, 32'h2F);
        chk("pt_busy", {31'd0, busy}, 0);
        @(negedge clk);
        cpu_MI = 0; cpu_bus_oe = 0; cpu_bus_out = 0;
        // full 16-byte load
        d0 = done_cnt;
        start_session();
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h10 + i), 4'(i), n);
            if (i == 1) chk("accept_gap", n, 3);
        end
        end_session();
        chk("full_count", {27'd0, load_count}, 16);
        chk("full_verr", {31'd0, verify_err}, 0);
        @(negedge clk);
        chk("full_halt_drop", {31'd0, cpu_halt}, 0);
        chk("full_busy_drop", {31'd0, busy}, 0);
        chk("full_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 16; i++) chk($sformatf("full_ram%0d", i), {24'd0, ram[i]}, {24'd0, ref_ram[i]});
        // early stop after 3 bytes
        d0 = done_cnt;
        start_session();
        for (int i = 0; i < 3; i++) send(8'(8'h30 + i), 4'(i), n);
        wait_ready(n);
        end_session();
        chk("early_count", {27'd0, load_count}, 3);
        @(negedge clk);
        chk("early_done_once", done_cnt - d0, 1);
        for (int i = 0; i < 16; i++) chk($sformatf("early_ram%0d", i), {24'd0, ram[i]}, {24'd0, ref_ram[i]});
        // read-back fault at address 5
        fault_en = 1;
        start_session();
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 4'(i), n);
        wait_ready(n);
        chk("verr_clean", {31'd0, verify_err}, 0);
        send(8'hE0, 4'd5, n);
        wait_ready(n);
        chk("verr_set", {31'd0, verify_err}, 1);
        end_session();
        @(negedge clk);
        fault_en = 0;
        chk("verr_held", {31'd0, verify_err}, 1);
        chk("verr_count", {27'd0, load_count}, 6);
        // abort before ack
        d0 = done_cnt;
        prog_req = 1;
        repeat (2) @(negedge clk);
        chk("abort_halt", {31'd0, cpu_halt}, 1);
        prog_req = 0;
        repeat (3) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_count", {27'd0, load_count}, 6);
        chk("abort_verr_kept", {31'd0, verify_err}, 1);
        // new session clears, then reset mid-WRITE
        start_session();
        chk("entry_verr_clr", {31'd0, verify_err}, 0);
        chk("entry_count_clr", {27'd0, load_count}, 0);
        send(8'h77, 4'd0, n);
        n = 0;
        while (!RI && n < 10) begin @(negedge clk); n++; end
        chk("ri_seen", {31'd0, RI}, 1);
        rst = 0;
        #1;
        chk("mr_RI", {31'd0, RI}, 0);
        chk("mr_MI", {31'd0, MI}, 0);
        chk("mr_oe", {31'd0, bus_oe}, 0);
        chk("mr_halt", {31'd0, cpu_halt}, 0);
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_count", {27'd0, load_count}, 0);
        cpu_MI = 1;
        #1;
        chk("mr_run_pt", {31'd0, MI}, 1);
        cpu_MI = 0;
        prog_req = 0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
